// File: rtl/nibble_rr_arbiter.sv
// Two-channel nibble FIFO feeder with a registered a/b/s output for the 2:1 mux stage.
// Define NIBBLE_ARB_FIXED_PRIO_EN for fixed priority (channel 0 first) instead of round robin.
module nibble_rr_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in0_valid,
  output logic                     in0_ready,
  input  logic [3:0]               in0_data,
  input  logic                     in1_valid,
  output logic                     in1_ready,
  input  logic [3:0]               in1_data,
  output logic [3:0]               out_a,
  output logic [3:0]               out_b,
  output logic                     out_s,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count0,
  output logic [$clog2(DEPTH):0]   count1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [3:0]          out_a_q, out_a_d;
  logic [3:0]          out_b_q, out_b_d;
  logic                out_s_q, out_s_d;
  logic                load, grant, gsel;
  logic [1:0]          vld, nonempty, rdy;
  logic [1:0][3:0]     din, head;
  logic [1:0][CW-1:0]  cnt;

  assign vld = {in1_valid, in0_valid};
  assign din = {in1_data, in0_data};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [3:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    // A full FIFO refuses the push even if it pops on the same edge.
    always_comb begin
      push  = vld[g] && (cnt_q != FULL);
      pop   = grant && (gsel == 1'(g));
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(pop);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= din[g];
    end

    assign rdy[g]      = (cnt_q != FULL);
    assign nonempty[g] = (cnt_q != '0);
    assign head[g]     = mem_q[rd_q];
    assign cnt[g]      = cnt_q;
  end

  assign in0_ready = rdy[0];
  assign in1_ready = rdy[1];
  assign count0    = cnt[0];
  assign count1    = cnt[1];

`ifdef NIBBLE_ARB_FIXED_PRIO_EN
  assign gsel = !nonempty[0];
`else
  logic rr_last_q, rr_last_d;

  assign gsel = (nonempty[0] && nonempty[1]) ? !rr_last_q : nonempty[1];

  always_comb begin
    rr_last_d = rr_last_q;
    if (grant) rr_last_d = gsel;
  end

  // Resetting to 1 lets channel 0 win the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last_q <= 1'b1;
    else        rr_last_q <= rr_last_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load) state_d = (|nonempty) ? ST_HOLD : ST_EMPTY;
  end

  always_comb begin
    out_valid = (state_q == ST_HOLD);
    load      = !out_valid || out_ready;
    grant     = load && (|nonempty);
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    out_s_d   = out_s_q;
    if (grant) begin
      out_s_d = gsel;
      if (gsel) out_b_d = head[1];
      else      out_a_d = head[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a_q <= '0;
      out_b_q <= '0;
      out_s_q <= 1'b0;
    end else begin
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      out_s_q <= out_s_d;
    end
  end

  assign out_a = out_a_q;
  assign out_b = out_b_q;
  assign out_s = out_s_q;

endmodule

// File: tb/tb_nibble_rr_arbiter.sv
// Directed and random stimulus for nibble_rr_arbiter, checked against a queue-based model.
module tb_nibble_rr_arbiter;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in0_valid, in1_valid, out_ready;
  logic [3:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic [3:0] out_a, out_b;
  logic       out_s, out_valid;
  logic [2:0] count0, count1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  bit         m_valid, m_s, m_rr;
  logic [3:0] m_a, m_b;

  nibble_rr_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .out_a(out_a), .out_b(out_b), .out_s(out_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_valid = 0; m_s = 0; m_rr = 1; m_a = 0; m_b = 0;
  endtask

  task automatic check_all();
    chk("out_valid", 8'(out_valid), 8'(m_valid));
    chk("out_a",     8'(out_a),     8'(m_a));
    chk("out_b",     8'(out_b),     8'(m_b));
    chk("out_s",     8'(out_s),     8'(m_s));
    chk("count0",    8'(count0),    8'(q0.size()));
    chk("count1",    8'(count1),    8'(q1.size()));
    chk("in0_ready", 8'(in0_ready), 8'(q0.size() != DEPTH));
    chk("in1_ready", 8'(in1_ready), 8'(q1.size() != DEPTH));
  endtask

  // One clock of stimulus; the model predicts the state after the edge.
  task automatic step(input bit v0, input logic [3:0] d0, input bit v1, input logic [3:0] d1,
                      input bit rdy, output bit acc0, output bit acc1);
    bit load, ch;
    @(negedge clk);
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    out_ready = rdy;
    acc0 = v0 && (q0.size() != DEPTH);
    acc1 = v1 && (q1.size() != DEPTH);
    load = !m_valid || rdy;
    if (load) begin
      if (q0.size() > 0 || q1.size() > 0) begin
`ifdef NIBBLE_ARB_FIXED_PRIO_EN
        ch = (q0.size() == 0);
`else
        if (q0.size() > 0 && q1.size() > 0) ch = !m_rr;
        else                                ch = (q0.size() == 0);
`endif
        if (ch) m_b = q1.pop_front();
        else    m_a = q0.pop_front();
        m_s = ch; m_rr = ch; m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    if (acc0) q0.push_back(d0);
    if (acc1) q1.push_back(d1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in0_valid = 0; in1_valid = 0; out_ready = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin : main
    bit a0, a1;
    int idx, sent, cyc;
    logic [3:0] s_seq[6];
    logic [3:0] y_seq[6];
    logic [3:0] bp_items[6];

    rst_n = 0; in0_valid = 0; in1_valid = 0; out_ready = 0;
    in0_data = 0; in1_data = 0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1;

    // Reset mid-stream with three items buffered
    step(1, 4'h1, 1, 4'h2, 0, a0, a1);
    step(1, 4'h3, 1, 4'h4, 0, a0, a1);
    chk("buffered_before_reset", 8'(count0 + count1), 8'd3);
    do_reset();
    step(1, 4'hA, 0, 4'h0, 1, a0, a1);
    chk("push_not_yet_valid", 8'(out_valid), 8'd0);
    step(0, 4'h0, 0, 4'h0, 0, a0, a1);
    chk("first_out_valid", 8'(out_valid), 8'd1);
    chk("first_out_a", 8'(out_a), 8'hA);
    chk("first_out_s", 8'(out_s), 8'd0);

`ifdef NIBBLE_ARB_FIXED_PRIO_EN
    do_reset();
    step(1, 4'h1, 1, 4'h9, 0, a0, a1);
    step(1, 4'h2, 1, 4'h8, 0, a0, a1);
    s_seq[0] = 4'(out_s);
    for (int k = 1; k < 4; k++) begin
      step(0, 4'h0, 0, 4'h0, 1, a0, a1);
      s_seq[k] = 4'(out_s);
    end
    chk("fixed_s0", 8'(s_seq[0]), 8'd0);
    chk("fixed_s1", 8'(s_seq[1]), 8'd0);
    chk("fixed_s2", 8'(s_seq[2]), 8'd1);
    chk("fixed_s3", 8'(s_seq[3]), 8'd1);
`else
    // Contention: alternating grants starting with channel 0
    do_reset();
    step(1, 4'h1, 1, 4'h9, 0, a0, a1);
    step(1, 4'h2, 1, 4'h8, 0, a0, a1);
    step(1, 4'h3, 1, 4'h7, 0, a0, a1);
    s_seq[0] = 4'(out_s); y_seq[0] = out_s ? out_b : out_a;
    for (int k = 1; k < 6; k++) begin
      step(0, 4'h0, 0, 4'h0, 1, a0, a1);
      s_seq[k] = 4'(out_s); y_seq[k] = out_s ? out_b : out_a;
    end
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_s%0d", k), 8'(s_seq[k]), 8'(k % 2));
    end
    chk("rr_y0", 8'(y_seq[0]), 8'h1);
    chk("rr_y1", 8'(y_seq[1]), 8'h9);
    chk("rr_y2", 8'(y_seq[2]), 8'h2);
    chk("rr_y3", 8'(y_seq[3]), 8'h8);
    chk("rr_y4", 8'(y_seq[4]), 8'h3);
    chk("rr_y5", 8'(y_seq[5]), 8'h7);
    step(0, 4'h0, 0, 4'h0, 1, a0, a1);
    chk("rr_drained", 8'(out_valid), 8'd0);
`endif

    // Backpressure: six items on channel 1 while the output is stalled
    do_reset();
    step(1, 4'h5, 0, 4'h0, 0, a0, a1);
    step(0, 4'h0, 0, 4'h0, 0, a0, a1);
    for (int k = 0; k < 6; k++) bp_items[k] = 4'(k + 11);
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      step(0, 4'h0, 1, bp_items[idx], 0, a0, a1);
      if (a1) idx++;
    end
    chk("bp_count1", 8'(count1), 8'd4);
    chk("bp_in1_ready", 8'(in1_ready), 8'd0);
    chk("bp_frozen_a", 8'(out_a), 8'h5);
    chk("bp_frozen_valid", 8'(out_valid), 8'd1);
    chk("bp_accepted", 8'(idx), 8'd4);
    cyc = 0;
    while ((idx < 6 || m_valid) && cyc < 40) begin
      step(0, 4'h0, idx < 6, (idx < 6) ? bp_items[idx] : 4'h0, 1, a0, a1);
      if (a1) idx++;
      cyc++;
    end
    chk("bp_all_sent", 8'(idx), 8'd6);
    chk("bp_drained", 8'(out_valid), 8'd0);

    // Full boundary: a full FIFO pops without pushing
    do_reset();
    for (int k = 1; k <= 5; k++) step(1, 4'(k), 0, 4'h0, 0, a0, a1);
    chk("full_count0", 8'(count0), 8'd4);
    chk("full_in0_ready", 8'(in0_ready), 8'd0);
    step(1, 4'h6, 0, 4'h0, 1, a0, a1);
    chk("full_no_push", 8'(a0), 8'd0);
    chk("full_count0_after_pop", 8'(count0), 8'd3);
    chk("full_ready_after_pop", 8'(in0_ready), 8'd1);

    // Wrap-around: 20 items through channel 0 with random backpressure
    do_reset();
    sent = 0; cyc = 0;
    while (sent < 20 && cyc < 400) begin
      step($urandom_range(0, 3) != 0, 4'(sent), 0, 4'h0, $urandom_range(0, 1) == 1, a0, a1);
      if (a0) sent++;
      cyc++;
    end
    chk("wrap_sent", 8'(sent), 8'd20);
    cyc = 0;
    while ((m_valid || q0.size() > 0) && cyc < 40) begin
      step(0, 4'h0, 0, 4'h0, 1, a0, a1);
      cyc++;
    end
    chk("wrap_drained", 8'(out_valid), 8'd0);

    // Random traffic on both channels
    do_reset();
    for (int k = 0; k < 200; k++) begin
      step($urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 1) == 1, 4'($urandom),
           $urandom_range(0, 2) != 0, a0, a1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
